// File: rtl/dmem_if.sv
// Bus bundle between the load/store controller, its two requesters (core LSU c_*, DMA/debug d_*)
// and the word-wide data memory.
interface dmem_if;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [2:0]  c_req_size;
  logic [31:0] c_req_addr, c_req_wdata;
  logic        c_rsp_valid, c_rsp_err;
  logic [31:0] c_rsp_rdata;

  logic        d_req_valid, d_req_ready, d_req_we;
  logic [2:0]  d_req_size;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;

  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  modport slave (
    input  c_req_valid, c_req_we, c_req_size, c_req_addr, c_req_wdata,
    output c_req_ready, c_rsp_valid, c_rsp_err, c_rsp_rdata,
    input  d_req_valid, d_req_we, d_req_size, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_rdata,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output c_req_valid, c_req_we, c_req_size, c_req_addr, c_req_wdata,
    input  c_req_ready, c_rsp_valid, c_rsp_err, c_rsp_rdata,
    output d_req_valid, d_req_we, d_req_size, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_rdata,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I load/store controller with round-robin arbitration between core and DMA in front of a word memory.
// Optional DMEM_CTRL_PERF_EN adds saturating accept/error counters.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_CTRL_PERF_EN
  ,
  output logic [31:0] c_acc_cnt,
  output logic [31:0] d_acc_cnt,
  output logic [31:0] err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, MERGE, RESP} state_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic        PORT_C = 1'b0;
  localparam logic        PORT_D = 1'b1;
  localparam logic [32:0] LIMIT  = 33'(DEPTH_WORDS) << 2;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        last_q, last_d;
  logic [31:0] buf_q, buf_d, rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        gnt_c, gnt_d, acc_c, acc_d;
  logic        is_b, is_h, is_w, size_ok, bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  // request decode of the latched request
  assign is_b    = (req_q.size[1:0] == 2'b00);
  assign is_h    = (req_q.size[1:0] == 2'b01);
  assign is_w    = (req_q.size == 3'b010);
  assign size_ok = (req_q.size == 3'b000) || (req_q.size == 3'b001) || (req_q.size == 3'b010) ||
                   (req_q.size == 3'b100) || (req_q.size == 3'b101);
  assign bad     = !size_ok || (req_q.we && req_q.size[2]) || (is_h && req_q.addr[0]) ||
                   (is_w && (req_q.addr[1:0] != 2'b00)) || ({1'b0, req_q.addr} >= LIMIT);

  assign byte_sel = bus.mem_rd[{req_q.addr[1:0], 3'b000} +: 8];
  assign half_sel = req_q.addr[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

  always_comb begin
    case (req_q.size)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = bus.mem_rd;
    endcase
  end

  always_comb begin
    merged = buf_q;
    if (is_b) merged[{req_q.addr[1:0], 3'b000} +: 8] = req_q.wdata[7:0];
    else      merged[{req_q.addr[1], 4'b0000} +: 16] = req_q.wdata[15:0];
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    last_d      = last_q;
    buf_d       = buf_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    gnt_c       = 1'b0;
    gnt_d       = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_wd  = req_q.wdata;
    case (state_q)
      IDLE: begin
        // tie goes to whoever was not granted last
        gnt_c = bus.c_req_valid && (!bus.d_req_valid || (last_q == PORT_D));
        gnt_d = bus.d_req_valid && !gnt_c;
        if (gnt_c) begin
          req_d   = '{PORT_C, bus.c_req_we, bus.c_req_size, bus.c_req_addr, bus.c_req_wdata};
          last_d  = PORT_C;
          state_d = EXEC;
        end else if (gnt_d) begin
          req_d   = '{PORT_D, bus.d_req_we, bus.d_req_size, bus.d_req_addr, bus.d_req_wdata};
          last_d  = PORT_D;
          state_d = EXEC;
        end
      end
      EXEC: begin
        err_d   = 1'b0;
        rdata_d = 32'h0;
        state_d = RESP;
        if (bad) begin
          err_d = 1'b1;
        end else if (!req_q.we) begin
          rdata_d = load_val;
        end else if (is_w) begin
          bus.mem_we = 1'b1;
        end else begin
          buf_d   = bus.mem_rd;
          state_d = MERGE;
        end
      end
      MERGE: begin
        bus.mem_we = 1'b1;
        bus.mem_wd = merged;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      last_q  <= PORT_D;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.c_req_ready = gnt_c && !rst;
  assign bus.d_req_ready = gnt_d && !rst;
  assign acc_c           = bus.c_req_valid && bus.c_req_ready;
  assign acc_d           = bus.d_req_valid && bus.d_req_ready;

  assign bus.c_rsp_valid = (state_q == RESP) && (req_q.port == PORT_C);
  assign bus.d_rsp_valid = (state_q == RESP) && (req_q.port == PORT_D);
  assign bus.c_rsp_rdata = rdata_q;
  assign bus.d_rsp_rdata = rdata_q;
  assign bus.c_rsp_err   = err_q;
  assign bus.d_rsp_err   = err_q;
  assign bus.mem_addr    = {req_q.addr[31:2], 2'b00};

`ifdef DMEM_CTRL_PERF_EN
  logic [31:0] c_acc_q, d_acc_q, err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_acc_q   <= '0;
      d_acc_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (acc_c && (c_acc_q != '1)) c_acc_q <= c_acc_q + 32'd1;
      if (acc_d && (d_acc_q != '1)) d_acc_q <= d_acc_q + 32'd1;
      if ((state_q == RESP) && err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign c_acc_cnt = c_acc_q;
  assign d_acc_cnt = d_acc_q;
  assign err_cnt   = err_cnt_q;
`else
  logic unused_acc;
  assign unused_acc = acc_c ^ acc_d;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: word memory model, core/DMA request tasks, hand-computed expectations.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();

`ifdef DMEM_CTRL_PERF_EN
  logic [31:0] c_acc_cnt, d_acc_cnt, err_cnt;
  dmem_ctrl #(.DEPTH_WORDS(256)) dut (.clk(clk), .rst(rst), .bus(bus),
    .c_acc_cnt(c_acc_cnt), .d_acc_cnt(d_acc_cnt), .err_cnt(err_cnt));
`else
  dmem_ctrl #(.DEPTH_WORDS(256)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SBU = 3'b100, S3 = 3'b011;

  logic [31:0] mem [256];
  assign bus.mem_rd = (bus.mem_addr < 32'd1024) ? mem[bus.mem_addr[9:2]] : 32'h0;
  always @(posedge clk) if (bus.mem_we && (bus.mem_addr < 32'd1024)) mem[bus.mem_addr[9:2]] <= bus.mem_wd;

  int we_cnt = 0, rsp_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_we) we_cnt++;
    if (bus.c_rsp_valid || bus.d_rsp_valid) rsp_cnt++;
  end

  int total = 0, bad = 0;
  int acc_c_m = 0, acc_d_m = 0, err_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit p, input bit v, input bit we, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin
      bus.c_req_valid = v; bus.c_req_we = we; bus.c_req_size = sz; bus.c_req_addr = a; bus.c_req_wdata = wd;
    end else begin
      bus.d_req_valid = v; bus.d_req_we = we; bus.d_req_size = sz; bus.d_req_addr = a; bus.d_req_wdata = wd;
    end
  endtask

  function automatic bit rdy_of(input bit p);
    return p ? bus.d_req_ready : bus.c_req_ready;
  endfunction
  function automatic bit rv_of(input bit p);
    return p ? bus.d_rsp_valid : bus.c_rsp_valid;
  endfunction

  // one request on port p (0=core, 1=DMA); lat counts edges from accept edge to the rsp cycle
  task automatic xact(input string tag, input bit p, input bit we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int n = 0, lat;
    bit rdy, rv;
    @(posedge clk); #1;
    drv(p, 1'b1, we, sz, a, wd);
    #1 rdy = rdy_of(p);
    while (!rdy && n < 20) begin
      @(posedge clk); #1; rdy = rdy_of(p); n++;
    end
    chk({tag, " accept"}, 32'(rdy), 32'd1);
    @(posedge clk); #1;
    drv(p, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    if (p) acc_d_m++; else acc_c_m++;
    lat = 1;
    rv  = rv_of(p);
    while (!rv && lat < 10) begin
      @(posedge clk); #1; lat++; rv = rv_of(p);
    end
    chk({tag, " rsp"}, 32'(rv), 32'd1);
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " other quiet"}, 32'(rv_of(!p)), 32'd0);
    chk({tag, " rdata"}, p ? bus.d_rsp_rdata : bus.c_rsp_rdata, exp_rd);
    chk({tag, " err"}, 32'(p ? bus.d_rsp_err : bus.c_rsp_err), 32'(exp_err));
    if (exp_err) err_m++;
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(rv_of(p)), 32'd0);
  endtask

  initial begin
    int w0, r0, rc, rd, nc, nd, gi;
    bit ac, ad;
    bit ord [8];
    logic [31:0] m4;

    // 1: reset with both requesters valid
    drv(0, 1'b1, 1'b0, SW, 32'h0, 32'h0);
    drv(1, 1'b1, 1'b0, SW, 32'h4, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst c_ready", 32'(bus.c_req_ready), 32'd0);
    chk("rst d_ready", 32'(bus.d_req_ready), 32'd0);
    chk("rst rsp_valid", 32'({bus.c_rsp_valid, bus.d_rsp_valid}), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst rdata", bus.c_rsp_rdata, 32'h0);
    chk("rst err", 32'(bus.c_rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("first tie c_ready", 32'(bus.c_req_ready), 32'd1);
    chk("first tie d_ready", 32'(bus.d_req_ready), 32'd0);
    drv(0, 1'b0, 1'b0, SW, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, SW, 32'h0, 32'h0);

    // 2: word store and load
    xact("sw 10", 0, 1'b1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw 10 mem", mem[4], 32'hDEADBEEF);
    xact("lw 10", 0, 1'b0, SW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // 3: sub-word read-modify-write and extension
    xact("sb 11", 0, 1'b1, SB, 32'h11, 32'h123456AA, 32'h0, 1'b0, 3);
    chk("sb 11 mem", mem[4], 32'hDEADAAEF);
    xact("lb 11", 0, 1'b0, SB, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    xact("lbu 11", 0, 1'b0, SBU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2);
    xact("lh 12", 0, 1'b0, SH, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    xact("lhu 12", 0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2);
    xact("sh 12", 0, 1'b1, SH, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3);
    chk("sh 12 mem", mem[4], 32'h1234AAEF);
    xact("dma sw 20", 1, 1'b1, SW, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    xact("dma lw 10", 1, 1'b0, SW, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 2);

    // 4: both valid continuously, last grant was DMA so core leads
    @(posedge clk); #1;
    drv(0, 1'b1, 1'b0, SW, 32'h10, 32'h0);
    drv(1, 1'b1, 1'b0, SW, 32'h20, 32'h0);
    #1;
    rc = 0; rd = 0; nc = 0; nd = 0; gi = 0;
    for (int cyc = 0; cyc < 100 && (rc < 4 || rd < 4); cyc++) begin
      ac = bus.c_req_valid && bus.c_req_ready;
      ad = bus.d_req_valid && bus.d_req_ready;
      chk("rr single ready", 32'(ac && ad), 32'd0);
      if (ac && gi < 8) begin ord[gi] = 1'b0; gi++; end
      if (ad && gi < 8) begin ord[gi] = 1'b1; gi++; end
      if (bus.c_rsp_valid) begin
        rc++;
        chk("rr c rdata", bus.c_rsp_rdata, 32'h1234AAEF);
        chk("rr c only", 32'(bus.d_rsp_valid), 32'd0);
      end
      if (bus.d_rsp_valid) begin
        rd++;
        chk("rr d rdata", bus.d_rsp_rdata, 32'hCAFEF00D);
      end
      @(posedge clk); #1;
      if (ac) begin nc++; acc_c_m++; if (nc == 4) bus.c_req_valid = 1'b0; end
      if (ad) begin nd++; acc_d_m++; if (nd == 4) bus.d_req_valid = 1'b0; end
      #1;
    end
    chk("rr c rsps", 32'(rc), 32'd4);
    chk("rr d rsps", 32'(rd), 32'd4);
    chk("rr grants", 32'(gi), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr order %0d", i), 32'(ord[i]), 32'(i % 2));

    // 5: errors leave memory untouched
    w0 = we_cnt; m4 = mem[4];
    xact("err lw 12", 0, 1'b0, SW, 32'h12, 32'h0, 32'h0, 1'b1, 2);
    xact("err sh 13", 0, 1'b1, SH, 32'h13, 32'h5555, 32'h0, 1'b1, 2);
    xact("err lw 400", 0, 1'b0, SW, 32'h400, 32'h0, 32'h0, 1'b1, 2);
    xact("err size 011", 1, 1'b0, S3, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    xact("err sbu store", 0, 1'b1, SBU, 32'h10, 32'h77, 32'h0, 1'b1, 2);
    chk("err no mem_we", 32'(we_cnt - w0), 32'd0);
    chk("err mem kept", mem[4], m4);

`ifdef DMEM_CTRL_PERF_EN
    chk("perf c_acc", c_acc_cnt, 32'(acc_c_m));
    chk("perf d_acc", d_acc_cnt, 32'(acc_d_m));
    chk("perf err", err_cnt, 32'(err_m));
`endif

    // 6: reset during MERGE of an SB
    xact("sw 14", 0, 1'b1, SW, 32'h14, 32'h11223344, 32'h0, 1'b0, 2);
    @(posedge clk); #1;
    drv(0, 1'b1, 1'b1, SB, 32'h15, 32'h55);
    #1 chk("sb 15 ready", 32'(bus.c_req_ready), 32'd1);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, SB, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("merge mem_we", 32'(bus.mem_we), 32'd1);
    r0 = rsp_cnt;
    rst = 1'b1;
    acc_c_m = 0; acc_d_m = 0; err_m = 0;
    #1;
    chk("rst merge mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst merge rsp", 32'(bus.c_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst merge no rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("rst merge mem", mem[5], 32'h11223344);
    xact("lw 14 after rst", 0, 1'b0, SW, 32'h14, 32'h0, 32'h11223344, 1'b0, 2);
    xact("lb 15 after rst", 1, 1'b0, SB, 32'h15, 32'h0, 32'h00000033, 1'b0, 2);
`ifdef DMEM_CTRL_PERF_EN
    chk("perf c_acc post rst", c_acc_cnt, 32'(acc_c_m));
    chk("perf d_acc post rst", d_acc_cnt, 32'(acc_d_m));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
